// File: rtl/led_bounce_if.sv
// Switch inputs and LED outputs of the LED bounce scanner, bundled as one port.
// The controller side (board switches / bench) uses master, the scanner uses slave.
interface led_bounce_if #(
    parameter int LED_COUNT = 4
);
    logic                 i_run;
    logic                 i_mode;
    logic [LED_COUNT-1:0] o_led;
    logic                 o_dir;
    logic                 o_stb;

    modport master (
        output i_run,
        output i_mode,
        input  o_led,
        input  o_dir,
        input  o_stb
    );

    modport slave (
        input  i_run,
        input  i_mode,
        output o_led,
        output o_dir,
        output o_stb
    );
endinterface

// File: rtl/led_bounce.sv
// One-hot LED scanner: bounces a lit LED between bit 0 and the MSB, or rotates
// it right, advancing once per carry-out strobe of a free-running prescaler.
module led_bounce #(
    parameter int COUNTER_WIDTH = 25,
    parameter int LED_COUNT     = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    led_bounce_if.slave   bus
);
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [COUNTER_WIDTH-1:0] counter = '0;
    logic                     stb     = 1'b0;
    logic [LED_COUNT-1:0]     led     = LED_COUNT'(1);
    logic                     dir     = DIR_UP;

    logic [COUNTER_WIDTH:0]   cnt_inc;
    logic [LED_COUNT-1:0]     led_next;
    logic                     dir_next;

    // Carry-out of the increment is the strobe: high one cycle per wrap.
    assign cnt_inc = {1'b0, counter} + {{COUNTER_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            counter <= '0;
            stb     <= 1'b0;
        end else if (bus.i_run) begin
            {stb, counter} <= cnt_inc;
        end else begin
            stb <= 1'b0;
        end
    end

    // Direction flips are decided on the pre-shift pattern: the neighbour
    // of the end bit tells whether the shifted value lands on that end.
    always_comb begin
        led_next = led;
        dir_next = dir;
        if (bus.i_mode) begin
            led_next = {led[0], led[LED_COUNT-1:1]};
            dir_next = DIR_DOWN;
        end else if (dir == DIR_UP) begin
            if (!led[LED_COUNT-1]) begin
                led_next = led << 1;
                dir_next = led[LED_COUNT-2] ? DIR_DOWN : DIR_UP;
            end else begin
                led_next = led >> 1;
                dir_next = DIR_DOWN;
            end
        end else begin
            if (!led[0]) begin
                led_next = led >> 1;
                dir_next = led[1] ? DIR_UP : DIR_DOWN;
            end else begin
                led_next = led << 1;
                dir_next = DIR_UP;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            led <= LED_COUNT'(1);
            dir <= DIR_UP;
        end else if (stb) begin
            led <= led_next;
            dir <= dir_next;
        end
    end

    assign bus.o_led = led;
    assign bus.o_dir = dir;
    assign bus.o_stb = stb;
endmodule
